// File: rtl/pezaris_merge_stage_if.sv
// Valid/ready bundle carrying the final Pezaris row vectors in and the merged product out.
interface pezaris_merge_stage_if #(parameter int W = 7);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   u_in;
  logic [W-1:0]   c_in;
  logic [W-1:0]   p_lo;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  modport master (
    output in_valid, u_in, c_in, p_lo, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, u_in, c_in, p_lo, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/pezaris_merge_stage.sv
// Two-register capture/merge of the last Pezaris row into a signed 2W product; no skid, out_ready feeds in_ready.
// Latency 2 edges, 1 beat/cycle; PEZARIS_MERGE_ACC_EN adds a wrapping accumulator of delivered products.
module pezaris_merge_stage #(
  parameter int W     = 7,
  parameter int ACC_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  pezaris_merge_stage_if.slave bus,
  output logic [7:0] beat_cnt
`ifdef PEZARIS_MERGE_ACC_EN
  ,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc_out
`endif
);

  logic           a_valid;
  logic [W-1:0]   u_q;
  logic [W-1:0]   c_q;
  logic [W-1:0]   p_q;
  logic           b_valid;
  logic [2*W-1:0] prod_q;
  logic [2*W-1:0] merged;
  logic           load_b;
  logic           accept;
  logic           xfer;

  assign load_b      = a_valid && (!b_valid || bus.out_ready);
  assign bus.in_ready = !a_valid || !b_valid || bus.out_ready;
  assign accept      = bus.in_valid && bus.in_ready;
  assign xfer        = b_valid && bus.out_ready;

  // Carry vector sits one bit above the sum vector; its top bit lands at 2^(2W) and is dropped by the cast.
  assign merged = {u_q, p_q} + (2*W)'({c_q, {(W+1){1'b0}}});

  assign bus.out_valid = b_valid;
  assign bus.product   = prod_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid  <= 1'b0;
      u_q      <= '0;
      c_q      <= '0;
      p_q      <= '0;
      b_valid  <= 1'b0;
      prod_q   <= '0;
      beat_cnt <= '0;
    end else begin
      if (accept) begin
        a_valid <= 1'b1;
        u_q     <= bus.u_in;
        c_q     <= bus.c_in;
        p_q     <= bus.p_lo;
      end else if (load_b) begin
        a_valid <= 1'b0;
      end

      if (load_b) begin
        prod_q  <= merged;
        b_valid <= 1'b1;
      end else if (xfer) begin
        b_valid <= 1'b0;
      end

      if (xfer && (beat_cnt != 8'hFF)) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end
  end

`ifdef PEZARIS_MERGE_ACC_EN
  logic [ACC_W-1:0] prod_ext;

  assign prod_ext = {{(ACC_W-2*W){prod_q[2*W-1]}}, prod_q};

  // Clear wins over accumulate but still keeps a product delivered on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out <= '0;
    end else if (acc_clr) begin
      acc_out <= xfer ? prod_ext : '0;
    end else if (xfer) begin
      acc_out <= acc_out + prod_ext;
    end
  end
`endif

endmodule

// File: tb/tb_pezaris_merge_stage.sv
// Bench for pezaris_merge_stage: vector table, hand-written corner sequences and a random run vs. an arithmetic model.
module tb_pezaris_merge_stage;
  localparam int W     = 7;
  localparam int ACC_W = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] beat_cnt;
`ifdef PEZARIS_MERGE_ACC_EN
  logic             acc_clr;
  logic [ACC_W-1:0] acc_out;
`endif

  pezaris_merge_stage_if #(.W(W)) bus();

  pezaris_merge_stage #(.W(W), .ACC_W(ACC_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .beat_cnt(beat_cnt)
`ifdef PEZARIS_MERGE_ACC_EN
    ,
    .acc_clr(acc_clr),
    .acc_out(acc_out)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Product from the arithmetic weights of each vector, reduced mod 2^14.
  function automatic logic [13:0] model_prod(input logic [6:0] u, input logic [6:0] c, input logic [6:0] p);
    int v;
    v = int'(u) * 128 + int'(p) + int'(c) * 256;
    return 14'(v % 16384);
  endfunction

  function automatic logic [ACC_W-1:0] sext(input logic [13:0] v);
    return {{(ACC_W-14){v[13]}}, v};
  endfunction

  // Scoreboard: products in flight, delivered count and running sum.
  logic [13:0]      exp_q[$];
  int               exp_beat = 0;
  logic [ACC_W-1:0] exp_acc = '0;
  bit               mon_en = 1'b0;
  bit               mon_xfer;
  logic [13:0]      mon_pv;

  always @(negedge clk) begin
    if (mon_en) begin
      check("beat_cnt_track", beat_cnt, exp_beat);
      check("in_ready_track", bus.in_ready, (exp_q.size() < 2) || bus.out_ready);
`ifdef PEZARIS_MERGE_ACC_EN
      check("acc_track", acc_out, exp_acc);
`endif
      if (rst) begin
        exp_q.delete();
        exp_beat = 0;
        exp_acc  = '0;
      end else begin
        mon_xfer = bus.out_valid && bus.out_ready;
        mon_pv   = '0;
        if (mon_xfer) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h expected none", bus.product);
          end else begin
            mon_pv = exp_q.pop_front();
            check("product_order", bus.product, mon_pv);
          end
          if (exp_beat < 255) exp_beat++;
        end
`ifdef PEZARIS_MERGE_ACC_EN
        if (acc_clr) exp_acc = mon_xfer ? sext(mon_pv) : '0;
        else if (mon_xfer) exp_acc = exp_acc + sext(mon_pv);
`endif
        if (bus.in_valid && bus.in_ready) exp_q.push_back(model_prod(bus.u_in, bus.c_in, bus.p_lo));
      end
    end
  end

  typedef struct {
    logic [6:0]  u;
    logic [6:0]  c;
    logic [6:0]  p;
    logic [13:0] exp;
  } vec_t;

  vec_t        tbl[8];
  logic [13:0] bp_exp[4];
  int          n_acc;

`ifdef PEZARIS_MERGE_ACC_EN
  task automatic send_one(input logic [6:0] u, input logic [6:0] c, input logic [6:0] p, input bit clr);
    bus.in_valid = 1'b1; bus.u_in = u; bus.c_in = c; bus.p_lo = p; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    acc_clr = clr;
    @(posedge clk); #1;
    acc_clr = 1'b0;
  endtask
`endif

  initial begin
    tbl[0] = '{7'h00, 7'h00, 7'h05, 14'h0005};
    tbl[1] = '{7'h7F, 7'h00, 7'h7F, 14'h3FFF};
    tbl[2] = '{7'h01, 7'h01, 7'h00, 14'h0180};
    tbl[3] = '{7'h01, 7'h40, 7'h00, 14'h0080};
    tbl[4] = '{7'h00, 7'h00, 7'h03, 14'h0003};
    tbl[5] = '{7'h7F, 7'h00, 7'h7B, 14'h3FFB};
    tbl[6] = '{7'h2A, 7'h15, 7'h11, 14'h2A11};
    tbl[7] = '{7'h7F, 7'h7F, 7'h7F, 14'h3EFF};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.u_in = '0; bus.c_in = '0; bus.p_lo = '0; bus.out_ready = 1'b0;
`ifdef PEZARIS_MERGE_ACC_EN
    acc_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_product", bus.product, 0);
    check("reset_beat_cnt", beat_cnt, 0);
    check("reset_in_ready", bus.in_ready, 1);

    // Single beats: two-edge latency, then transfer.
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.u_in = tbl[i].u; bus.c_in = tbl[i].c; bus.p_lo = tbl[i].p;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d_not_early", i), bus.out_valid, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", i), bus.out_valid, 1);
      check($sformatf("vec%0d_product", i), bus.product, tbl[i].exp);
      @(posedge clk); #1;
      check($sformatf("vec%0d_drained", i), bus.out_valid, 0);
      check($sformatf("vec%0d_beat_cnt", i), beat_cnt, i + 1);
    end

    // Backpressure: only two beats fit, the held product must not change.
    for (int k = 0; k < 4; k++) bp_exp[k] = model_prod(7'(k + 1), 7'(k + 2), 7'(3 * k + 1));
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      bus.in_valid = 1'b1;
      bus.u_in = 7'(n_acc + 1); bus.c_in = 7'(n_acc + 2); bus.p_lo = 7'(3 * n_acc + 1);
      #1;
      if (bus.in_ready) n_acc++;
      @(posedge clk); #1;
    end
    check("bp_accepted_two", n_acc, 2);
    check("bp_in_ready_low", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_product_held", bus.product, bp_exp[0]);
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && n_acc < 4; cyc++) begin
      bus.in_valid = 1'b1;
      bus.u_in = 7'(n_acc + 1); bus.c_in = 7'(n_acc + 2); bus.p_lo = 7'(3 * n_acc + 1);
      #1;
      if (bus.in_ready) n_acc++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("bp_accepted_all", n_acc, 4);
    for (int cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++) begin
      @(posedge clk); #1;
    end
    check("bp_drained", exp_q.size(), 0);
    check("bp_beat_cnt", beat_cnt, 12);

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.u_in = 7'h11; bus.c_in = 7'h22; bus.p_lo = 7'h33;
    repeat (3) @(posedge clk);
    #1;
    check("full_in_ready_low", bus.in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_full_out_valid", bus.out_valid, 0);
    check("rst_full_beat_cnt", beat_cnt, 0);
    check("rst_full_product", bus.product, 0);
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      check($sformatf("rst_no_stale_%0d", cyc), bus.out_valid, 0);
    end

`ifdef PEZARIS_MERGE_ACC_EN
    send_one(7'h00, 7'h00, 7'h03, 1'b0);
    send_one(7'h7F, 7'h00, 7'h7B, 1'b0);
    send_one(7'h00, 7'h00, 7'h0A, 1'b0);
    check("acc_sum_8", acc_out, 20'd8);
    send_one(7'h00, 7'h00, 7'h07, 1'b1);
    check("acc_clr_xfer_7", acc_out, 20'd7);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    check("acc_clr_alone_0", acc_out, 20'd0);
`endif

    // Random traffic; long enough to saturate beat_cnt.
    for (int cyc = 0; cyc < 700; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.u_in      = 7'($urandom);
      bus.c_in      = 7'($urandom);
      bus.p_lo      = 7'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
`ifdef PEZARIS_MERGE_ACC_EN
      acc_clr = ($urandom_range(0, 15) == 0);
`endif
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
`ifdef PEZARIS_MERGE_ACC_EN
    acc_clr = 1'b0;
`endif
    for (int cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++) begin
      @(posedge clk); #1;
    end
    check("rand_drained", exp_q.size(), 0);
    check("beat_cnt_saturated", beat_cnt, 255);
    @(posedge clk); #1;
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pezaris_merge_stage.md
# pezaris_merge_stage

Vector-merging stage directly downstream of the Pezaris array's final full-adder row. Captures the last row's 7-bit sum and carry vectors plus the 7 low product bits already resolved by earlier rows, then resolves them into a signed 14-bit product. A two-stage valid/ready pipeline with backpressure wraps the carry-propagate merge. An optional multiply-accumulate register sits behind it.

## Interface
- W, 7: width of the sum/carry vectors from the array row; product width is 2*W.
- ACC_W, 20: accumulator width; only used when the accumulate feature is compiled in.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  row outputs and low bits are valid.
- in_ready  out  1  stage can accept a beat this cycle.
- u_in  in  W  sum vector from the last array row (weight 2^W .. 2^(2W-1)).
- c_in  in  W  carry vector from the last array row (weight 2^(W+1) .. 2^(2W)).
- p_lo  in  W  product bits 0..W-1 resolved by earlier rows.
- out_valid  out  1  product register holds a valid result.
- out_ready  in  1  consumer accepts the product this cycle.
- product  out  2W  signed two's-complement product.
- beat_cnt  out  8  number of products delivered; saturates at 255.
- acc_clr  in  1  (accumulate build only) clear the accumulator.
- acc_out  out  ACC_W  (accumulate build only) running signed sum of delivered products.

## Operation
- Stage A (capture): on in_valid && in_ready, register u_in, c_in and p_lo; set a_valid.
- Stage B (merge): product = ({u_in, p_lo} + {c_in, W+1'b0}) mod 2^(2W), computed from the Stage A registers. The carry out of bit 2W-1 is discarded. The result is interpreted as signed.
- Stage B loads when a_valid && (!out_valid || out_ready).
- A loaded Stage B clears a_valid unless Stage A captures a new beat in the same cycle.
- Handshake: in_ready = !a_valid || (!out_valid || out_ready). Combinational path from out_ready to in_ready is allowed; there is no skid buffer.
- out_valid holds, with product stable, until out_ready is sampled high. The transfer happens on out_valid && out_ready.
- beat_cnt increments on each output transfer and stops at 255.
- Reset values: a_valid=0, out_valid=0, product=0, beat_cnt=0, acc_out=0. in_ready is 1 in the cycle after reset.
- A reset asserted mid-stream drops every in-flight beat. No output transfer is reported on the reset cycle.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1. That is 2 registers.
- Throughput: 1 beat/cycle with out_ready held high.
- Full pipeline with out_ready=0: in_ready=0, and both stages hold their contents unchanged.
- Simultaneous output transfer and new input while full: Stage B loads from Stage A, and Stage A captures the new beat in the same edge. No bubble is inserted.
- Accumulator updates on the output-transfer edge.
- acc_clr has priority over accumulation: on clear with a concurrent transfer, acc_out becomes that product sign-extended, not 0.
- acc_clr with no transfer gives acc_out=0.
- The accumulator wraps modulo 2^ACC_W with no saturation.

## Configuration
- Macro: PEZARIS_MERGE_ACC_EN.
- When defined: acc_clr and acc_out ports and the ACC_W accumulator exist, and acc_out adds the sign-extended product on every output transfer.
- When undefined: those ports and the accumulator are absent. Behaviour of all other ports is identical in both builds.

## Test plan
- Reset, then hold in_valid=0 -> out_valid=0, product=0, beat_cnt=0, in_ready=1.
- u_in=7'h00, c_in=7'h00, p_lo=7'h05, one beat, out_ready=1 -> after 2 edges out_valid=1, product=14'h0005, beat_cnt becomes 1 on the transfer.
- u_in=7'h7F, c_in=7'h00, p_lo=7'h7F -> product=14'h3FFF (-1).
- u_in=7'h01, c_in=7'h01, p_lo=7'h00 -> product=0x0080+0x0100=14'h0180.
- Same stimulus with c_in=7'h40 -> bit 14 is dropped and product=14'h0080.
- Backpressure: stream 4 beats with out_ready=0 -> in_ready falls after 2 accepted. Then out_ready=1 -> all 4 products are delivered in order with no loss or duplication.
- Accumulate build: products 3, -5, 10 delivered -> acc_out=8. Then acc_clr with a concurrent transfer of 7 -> acc_out=7. Then acc_clr alone -> acc_out=0.
- Reset with both stages full -> the next cycle has out_valid=0 and beat_cnt=0, and no stale product is emitted.
